// File: rtl/bcd_display_encoder_if.sv
// rtl/bcd_display_encoder_if.sv - start/busy/done handshake bundle for the BCD display encoder
interface bcd_display_encoder_if #(
  parameter int DIGITS = 6,
  parameter int IN_W   = 20
) ();
  logic                  start;
  logic [IN_W-1:0]       binIn;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcdOut;

  modport master (output start, output binIn, input busy, input done, input ovf, input bcdOut);
  modport slave  (input start, input binIn, output busy, output done, output ovf, output bcdOut);
endinterface

// File: rtl/bcd_display_encoder.sv
// rtl/bcd_display_encoder.sv - iterative double-dabble binary-to-BCD converter, one input bit per clock
// Produces an optional sign nibble plus saturating BCD digits for the 7-segment controller.
module bcd_display_encoder #(
  parameter int         DIGITS   = 6,
  parameter int         IN_W     = 20,
  parameter int         SIGNED   = 0,
  parameter logic [3:0] NEG_CODE = 4'hA,
  parameter logic [3:0] POS_CODE = 4'hF
) (
  input  logic                   clk,
  input  logic                   resetn,
  bcd_display_encoder_if.slave   bus
);

  localparam int ND = DIGITS - SIGNED;
  localparam int CW = $clog2(IN_W + 1);

  function automatic logic [63:0] max_value(input int n);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < n; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value(ND);
  localparam logic [4*DIGITS-1:0] RST_VAL =
    (SIGNED != 0) ? {POS_CODE, {(4*DIGITS-4){1'b0}}} : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state, state_n;
  logic [IN_W-1:0]        mag, mag_in;
  logic [4*ND-1:0]        work, adj, digits;
  logic [4*ND+IN_W-1:0]   shifted;
  logic [CW-1:0]          cnt;
  logic                   neg, ovf_pend, last_shift;
  logic [4*DIGITS-1:0]    result;

  // A negative two's complement input is negated; the most-negative value maps onto 2^(IN_W-1) unsigned.
  assign mag_in     = ((SIGNED != 0) && bus.binIn[IN_W-1]) ? (~bus.binIn + IN_W'(1)) : bus.binIn;
  assign last_shift = (cnt == CW'(IN_W - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = SHIFT;
      SHIFT:   if (last_shift) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  always_comb begin
    adj = work;
    for (int i = 0; i < ND; i++) begin
      if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
    shifted = {adj, mag} << 1;
    digits  = ovf_pend ? {ND{4'h9}} : work;
  end

  generate
    if (SIGNED != 0) begin : g_signed
      assign result = {(neg ? NEG_CODE : POS_CODE), digits};
    end else begin : g_unsigned
      assign result = digits;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mag        <= '0;
      work       <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      ovf_pend   <= 1'b0;
      bus.done   <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.bcdOut <= RST_VAL;
    end else begin
      bus.done <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            mag      <= mag_in;
            neg      <= (SIGNED != 0) && bus.binIn[IN_W-1];
            ovf_pend <= (64'(mag_in) > MAX_VAL);
            work     <= '0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          {work, mag} <= shifted;
          cnt         <= cnt + CW'(1);
        end
        DONE: begin
          bus.bcdOut <= result;
          bus.ovf    <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

endmodule
